// File: rtl/dekatron_pkg.sv
// dekatron_pkg
//   Shared definitions for the dekatron step driver and its display path:
//   the driver state enum, the number of main cathodes (DEK_DIGITS), and the
//   one-hot <-> BCD conversion helpers.
package dekatron_pkg;

  localparam int DEK_DIGITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_SETTLE,
    ST_LOAD,
    ST_DONE
  } dek_state_e;

  // Decoded main-cathode state: valid is low when zero or several cathodes glow.
  typedef struct packed {
    logic       valid;
    logic [3:0] bcd;
  } dek_decode_t;

  // One-hot of a BCD digit; digits above 9 have no cathode and map to all-zero.
  function automatic logic [DEK_DIGITS-1:0] bcd_to_onehot(input logic [3:0] bcd);
    logic [DEK_DIGITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < DEK_DIGITS; i++) begin
      if (bcd == 4'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // BCD of a one-hot cathode vector; 4'hF with valid=0 unless exactly one bit is set.
  function automatic dek_decode_t onehot_to_bcd(input logic [DEK_DIGITS-1:0] oh);
    dek_decode_t r;
    int unsigned ones;
    ones    = 0;
    r.valid = 1'b0;
    r.bcd   = 4'hF;
    for (int i = 0; i < DEK_DIGITS; i++) begin
      if (oh[i]) begin
        ones  = ones + 1;
        r.bcd = 4'(i);
      end
    end
    if (ones == 1) r.valid = 1'b1;
    else           r.bcd   = 4'hF;
    return r;
  endfunction

  // Digit the tube should land on after one step from d (modulo 10).
  function automatic logic [3:0] dek_step_digit(input logic [3:0] d, input logic inc);
    if (inc) return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/dekatron_decode.sv
// dekatron_decode
//   Combinational decode of the dekatron main-cathode one-hot vector into a
//   BCD digit plus a valid flag. Shared with the display path.
//   Ports:
//     one_hot [DEK_DIGITS-1:0] in  : main-cathode state from the tube
//     bcd     [3:0]            out : decoded digit, 4'hF when not one-hot
//     valid                    out : 1 when exactly one cathode is lit
module dekatron_decode
  import dekatron_pkg::*;
(
  input  logic [DEK_DIGITS-1:0] one_hot,
  output logic [3:0]            bcd,
  output logic                  valid
);

  dek_decode_t dec;

  always_comb begin
    dec   = onehot_to_bcd(one_hot);
    bcd   = dec.bcd;
    valid = dec.valid;
  end

endmodule

// File: rtl/dekatron_step_driver.sv
// dekatron_step_driver
//   Drives the two guide electrodes of a counting dekatron to move the glow
//   one cathode up or down, or writes a digit directly through DekIn, then
//   waits for the glow to settle and checks where it landed.
//   Parameters:
//     PULSE_WIDTH : cycles each guide phase is held (1..255)
//     SETTLE      : idle cycles after the last phase before checking (1..255)
//   Ports:
//     hsClk, Rst           : clock, asynchronous active-high reset
//     Request, Dir         : start one step (Dir 1 = up, 0 = down), IDLE only
//     LoadReq, LoadDigit   : write a BCD digit, IDLE only, wins over Request
//     DekOut [9:0]         : one-hot main-cathode state from the tube
//     PulseRight/PulseLeft : guide drives, never both high
//     DekIn [9:0]          : one-hot write value, non-zero only in LOAD
//     Busy                 : high while not IDLE
//     Ack, Carry, Error    : completion pulse and its qualified flags
//     Digit [3:0]          : live BCD decode of DekOut (4'hF if not one-hot)
module dekatron_step_driver
  import dekatron_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned SETTLE      = 4
) (
  input  logic                  hsClk,
  input  logic                  Rst,
  input  logic                  Request,
  input  logic                  Dir,
  input  logic                  LoadReq,
  input  logic [3:0]            LoadDigit,
  input  logic [DEK_DIGITS-1:0] DekOut,
  output logic                  PulseRight,
  output logic                  PulseLeft,
  output logic [DEK_DIGITS-1:0] DekIn,
  output logic                  Busy,
  output logic                  Ack,
  output logic                  Carry,
  output logic                  Error,
  output logic [3:0]            Digit
);

  // The shared down-counter runs from N-1 to 0, so a phase lasts N cycles.
  localparam logic [7:0] PW_RELOAD     = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);

  dek_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  is_load_q, is_load_d;
  logic [3:0]            start_digit_q, start_digit_d;
  logic [3:0]            load_digit_q, load_digit_d;
  logic                  pulse_right_q, pulse_right_d;
  logic                  pulse_left_q, pulse_left_d;
  logic [DEK_DIGITS-1:0] dek_in_q, dek_in_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  carry_q, carry_d;
  logic                  error_q, error_d;

  logic [3:0]            digit_w;
  logic                  digit_valid_w;
  logic [3:0]            expected_w;

  dekatron_decode u_decode (
    .one_hot (DekOut),
    .bcd     (digit_w),
    .valid   (digit_valid_w)
  );

  assign expected_w = dek_step_digit(start_digit_q, dir_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    is_load_d     = is_load_q;
    start_digit_d = start_digit_q;
    load_digit_d  = load_digit_q;
    dek_in_d      = '0;
    ack_d         = 1'b0;
    carry_d       = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (LoadReq) begin
          state_d      = ST_LOAD;
          is_load_d    = 1'b1;
          load_digit_d = LoadDigit;
          dek_in_d     = bcd_to_onehot(LoadDigit);
        end else if (Request) begin
          state_d       = ST_PH1;
          is_load_d     = 1'b0;
          dir_d         = Dir;
          start_digit_d = digit_w;
          cnt_d         = PW_RELOAD;
        end
      end

      ST_PH1: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_PH2;
          cnt_d   = PW_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_PH2: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_RELOAD;
      end

      // The result flags are captured on the edge into DONE so that they are
      // valid for exactly the cycle Ack is high.
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          if (is_load_q) begin
            error_d = (load_digit_q > 4'd9) || !digit_valid_w ||
                      (digit_w != load_digit_q);
          end else begin
            error_d = (start_digit_q == 4'hF) || !digit_valid_w ||
                      (digit_w != expected_w);
            carry_d = ( dir_q && (start_digit_q == 4'd0 + 4'd9) && (digit_w == 4'd0)) ||
                      (!dir_q && (start_digit_q == 4'd0)        && (digit_w == 4'd9));
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Guide outputs are registered from the next state so they line up with
    // the phase they belong to; up-steps lead with the right guide.
    pulse_right_d = ((state_d == ST_PH1) &&  dir_d) || ((state_d == ST_PH2) && !dir_d);
    pulse_left_d  = ((state_d == ST_PH1) && !dir_d) || ((state_d == ST_PH2) &&  dir_d);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge hsClk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      dir_q         <= 1'b0;
      is_load_q     <= 1'b0;
      start_digit_q <= 4'd0;
      load_digit_q  <= 4'd0;
      pulse_right_q <= 1'b0;
      pulse_left_q  <= 1'b0;
      dek_in_q      <= '0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      carry_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      is_load_q     <= is_load_d;
      start_digit_q <= start_digit_d;
      load_digit_q  <= load_digit_d;
      pulse_right_q <= pulse_right_d;
      pulse_left_q  <= pulse_left_d;
      dek_in_q      <= dek_in_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      carry_q       <= carry_d;
      error_q       <= error_d;
    end
  end

  assign PulseRight = pulse_right_q;
  assign PulseLeft  = pulse_left_q;
  assign DekIn      = dek_in_q;
  assign Busy       = busy_q;
  assign Ack        = ack_q;
  assign Carry      = carry_q;
  assign Error      = error_q;
  assign Digit      = digit_w;

endmodule

// File: tb/tb_dekatron_step_driver.sv
// tb_dekatron_step_driver
//   Bench for dekatron_step_driver with a behavioural dekatron tube attached:
//   the tube glow moves to a guide when that guide is pulsed, on to the second
//   guide when the other one is pulsed, and drops onto the next main cathode
//   when both guides are released; a write through DekIn sets the glow directly.
module tb_dekatron_step_driver;

  localparam int PW       = 4;
  localparam int ST       = 4;
  localparam int STEP_LAT = 2 * PW + ST + 1;
  localparam int LOAD_LAT = ST + 2;

  logic       hsClk = 1'b0;
  logic       Rst = 1'b1;
  logic       Request = 1'b0;
  logic       Dir = 1'b0;
  logic       LoadReq = 1'b0;
  logic [3:0] LoadDigit = 4'd0;
  logic [9:0] DekOut;
  logic       PulseRight, PulseLeft;
  logic [9:0] DekIn;
  logic       Busy, Ack, Carry, Error;
  logic [3:0] Digit;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cur_digit = 0;

  // Tube state: glow position (0 main, 1 first guide, 2 second guide),
  // direction of travel, and the lit main cathode.
  int       dek_main = 0;
  int       dek_pos = 0;
  bit       dek_cw = 1'b0;
  bit       force_en = 1'b0;
  logic [9:0] force_val = 10'd0;

  always #5 hsClk = ~hsClk;

  dekatron_step_driver #(.PULSE_WIDTH(PW), .SETTLE(ST)) dut (
    .hsClk      (hsClk),
    .Rst        (Rst),
    .Request    (Request),
    .Dir        (Dir),
    .LoadReq    (LoadReq),
    .LoadDigit  (LoadDigit),
    .DekOut     (DekOut),
    .PulseRight (PulseRight),
    .PulseLeft  (PulseLeft),
    .DekIn      (DekIn),
    .Busy       (Busy),
    .Ack        (Ack),
    .Carry      (Carry),
    .Error      (Error),
    .Digit      (Digit)
  );

  function automatic logic [9:0] onehot10(input int d);
    logic [9:0] v;
    v = 10'd0;
    if (d >= 0 && d <= 9) v[d] = 1'b1;
    return v;
  endfunction

  assign DekOut = force_en ? force_val : onehot10(dek_main);

  // The glow follows the guides as they were driven during the last cycle.
  always @(posedge hsClk) begin
    if (DekIn != 10'd0) begin
      for (int i = 0; i < 10; i++) if (DekIn[i]) dek_main <= i;
      dek_pos <= 0;
    end else begin
      case (dek_pos)
        0: begin
          if (PulseRight && !PulseLeft)      begin dek_pos <= 1; dek_cw <= 1'b1; end
          else if (PulseLeft && !PulseRight) begin dek_pos <= 1; dek_cw <= 1'b0; end
        end
        1: begin
          if (dek_cw ? (PulseLeft && !PulseRight) : (PulseRight && !PulseLeft)) dek_pos <= 2;
          else if (!PulseRight && !PulseLeft) dek_pos <= 0;
        end
        default: begin
          if (!PulseRight && !PulseLeft) begin
            dek_main <= dek_cw ? (dek_main + 1) % 10 : (dek_main + 9) % 10;
            dek_pos  <= 0;
          end
        end
      endcase
    end
  end

  // One comparison: count it, and report it if actual and required differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_vectors++;
    if (actual !== required) begin
      n_miscompares++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
    end
  endtask

  // Start one operation and follow it cycle by cycle until Ack (or give up),
  // tallying cycles where guides, DekIn or Busy were not what they should be.
  task automatic applyStimulus(input bit is_load, input bit dir, input logic [3:0] ld,
                               input bit also_req, output int lat, output logic c,
                               output logic e, output logic [3:0] dg,
                               output int guide_errs, output int busy_errs,
                               output bit post_ok);
    logic       exp_r, exp_l;
    logic [9:0] exp_in;
    lat = 0; c = 1'b0; e = 1'b0; dg = 4'd0; guide_errs = 0; busy_errs = 0;
    @(negedge hsClk);
    Request   = (!is_load) || also_req;
    LoadReq   = is_load;
    Dir       = dir;
    LoadDigit = ld;
    for (int k = 1; k <= 64; k++) begin
      @(negedge hsClk);
      if (k == 1) begin
        Request = 1'b0;
        LoadReq = 1'b0;
      end
      exp_r = 1'b0; exp_l = 1'b0; exp_in = 10'd0;
      if (is_load) begin
        if (k == 1 && ld <= 4'd9) exp_in = onehot10(int'(ld));
      end else if (k <= PW) begin
        exp_r = dir; exp_l = !dir;
      end else if (k <= 2 * PW) begin
        exp_r = !dir; exp_l = dir;
      end
      if ({PulseRight, PulseLeft, DekIn} !== {exp_r, exp_l, exp_in}) guide_errs++;
      if (Busy !== 1'b1) busy_errs++;
      if (Ack === 1'b1) begin
        lat = k; c = Carry; e = Error; dg = Digit;
        break;
      end
    end
    @(negedge hsClk);
    post_ok = (Ack === 1'b0) && (Busy === 1'b0);
  endtask

  // Apply one operation and compare everything it should produce.
  task automatic runOp(input string name, input bit is_load, input bit dir,
                       input logic [3:0] ld, input bit also_req, input logic exp_c,
                       input logic exp_e, input logic [3:0] exp_dg);
    int lat, guide_errs, busy_errs;
    logic c, e;
    logic [3:0] dg;
    bit post_ok;
    applyStimulus(is_load, dir, ld, also_req, lat, c, e, dg, guide_errs, busy_errs, post_ok);
    checkOutput({name, " ack latency"}, 32'(lat), 32'(is_load ? LOAD_LAT : STEP_LAT));
    checkOutput({name, " guide/write cycles wrong"}, 32'(guide_errs), 32'd0);
    checkOutput({name, " busy-low cycles"}, 32'(busy_errs), 32'd0);
    checkOutput({name, " carry"}, 32'(c), 32'(exp_c));
    checkOutput({name, " error"}, 32'(e), 32'(exp_e));
    checkOutput({name, " digit"}, 32'(dg), 32'(exp_dg));
    checkOutput({name, " idle after ack"}, 32'(post_ok), 32'd1);
  endtask

  typedef struct {
    string      name;
    bit         is_load;
    bit         dir;
    logic [3:0] ld;
    bit         also_req;
    logic       exp_c;
    logic       exp_e;
    logic [3:0] exp_dg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int ack_count, first_ack, second_ack;
    logic [3:0] last_digit;
    bit r_load, r_dir, r_also;
    logic [3:0] r_ld;
    logic r_c, r_e;
    int r_dg;

    // Directed table; the tube starts on cathode 0.
    vecs[0]  = '{"load9",          1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 4'd9};
    vecs[1]  = '{"inc_from9",      1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{"dec_from0",      1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd9};
    vecs[3]  = '{"load5_with_req", 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 4'd5};
    vecs[4]  = '{"inc_5_6",        1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd6};
    vecs[5]  = '{"dec_6_5",        1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd5};
    vecs[6]  = '{"load12_bad",     1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 1'b1, 4'd5};
    vecs[7]  = '{"load0",          1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0};
    vecs[8]  = '{"inc_0_1",        1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd1};
    vecs[9]  = '{"dec_1_0",        1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{"dec_0_9",        1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd9};
    vecs[11] = '{"load15_bad",     1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1, 4'd9};

    // Reset values while Rst is held.
    repeat (3) @(negedge hsClk);
    checkOutput("reset PulseRight", 32'(PulseRight), 32'd0);
    checkOutput("reset PulseLeft", 32'(PulseLeft), 32'd0);
    checkOutput("reset DekIn", 32'(DekIn), 32'd0);
    checkOutput("reset Busy", 32'(Busy), 32'd0);
    checkOutput("reset Ack", 32'(Ack), 32'd0);
    checkOutput("reset Carry", 32'(Carry), 32'd0);
    checkOutput("reset Error", 32'(Error), 32'd0);
    checkOutput("reset Digit", 32'(Digit), 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i].name, vecs[i].is_load, vecs[i].dir, vecs[i].ld, vecs[i].also_req,
            vecs[i].exp_c, vecs[i].exp_e, vecs[i].exp_dg);
    end
    cur_digit = 9;

    // A Request pulsed during PH2 must not start a second step.
    @(negedge hsClk);
    Request = 1'b1; Dir = 1'b1;
    ack_count = 0; last_digit = 4'd0;
    for (int k = 1; k <= STEP_LAT + 10; k++) begin
      @(negedge hsClk);
      if (Ack === 1'b1) begin ack_count++; last_digit = Digit; end
      Request = (k == PW + 2);
    end
    checkOutput("req_in_ph2 ack count", 32'(ack_count), 32'd1);
    checkOutput("req_in_ph2 digit", 32'(last_digit), 32'(( cur_digit + 1) % 10));
    checkOutput("req_in_ph2 busy at end", 32'(Busy), 32'd0);
    cur_digit = (cur_digit + 1) % 10;

    // Request held through Ack: the second step starts from the IDLE cycle.
    @(negedge hsClk);
    Request = 1'b1; Dir = 1'b0;
    first_ack = 0; second_ack = 0; last_digit = 4'd0;
    for (int k = 1; k <= 2 * STEP_LAT + 10; k++) begin
      @(negedge hsClk);
      if (Ack === 1'b1) begin
        if (first_ack == 0) first_ack = k;
        else if (second_ack == 0) second_ack = k;
        last_digit = Digit;
      end
      if (k == STEP_LAT + 2) Request = 1'b0;
    end
    Request = 1'b0;
    checkOutput("back_to_back first ack", 32'(first_ack), 32'(STEP_LAT));
    checkOutput("back_to_back second ack", 32'(second_ack), 32'(2 * STEP_LAT + 1));
    checkOutput("back_to_back digit", 32'(last_digit), 32'((cur_digit + 8) % 10));
    cur_digit = (cur_digit + 8) % 10;

    // Reset in PH1 drops the guides at once and no Ack follows.
    @(negedge hsClk);
    Request = 1'b1; Dir = 1'b1;
    @(negedge hsClk);
    Request = 1'b0;
    checkOutput("rst_in_ph1 right guide before reset", 32'(PulseRight), 32'd1);
    @(posedge hsClk);
    #2 Rst = 1'b1;
    #1;
    checkOutput("rst_in_ph1 PulseRight", 32'(PulseRight), 32'd0);
    checkOutput("rst_in_ph1 PulseLeft", 32'(PulseLeft), 32'd0);
    checkOutput("rst_in_ph1 Busy", 32'(Busy), 32'd0);
    @(negedge hsClk);
    Rst = 1'b0;
    ack_count = 0;
    for (int k = 0; k < STEP_LAT + 5; k++) begin
      @(negedge hsClk);
      if (Ack === 1'b1) ack_count++;
    end
    checkOutput("rst_in_ph1 ack count", 32'(ack_count), 32'd0);
    checkOutput("rst_in_ph1 digit kept", 32'(Digit), 32'(cur_digit));

    // Two cathodes lit before the step: Digit reads F and the step is flagged.
    force_en = 1'b1; force_val = 10'b0000000011;
    @(negedge hsClk);
    checkOutput("multi_hot digit", 32'(Digit), 32'hF);
    runOp("multi_hot step", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'hF);
    force_en = 1'b0;
    runOp("resync load4", 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4);
    cur_digit = 4;

    // Random mix of steps and loads against the modulo-10 counting rules.
    for (int i = 0; i < 30; i++) begin
      r_load = ($urandom_range(0, 2) == 0);
      r_dir  = 1'($urandom_range(0, 1));
      r_also = 1'($urandom_range(0, 1));
      r_ld   = 4'($urandom_range(0, 11));
      if (r_load) begin
        r_c  = 1'b0;
        r_e  = (r_ld > 4'd9);
        r_dg = (r_ld <= 4'd9) ? int'(r_ld) : cur_digit;
      end else begin
        r_e  = 1'b0;
        r_c  = r_dir ? (cur_digit == 9) : (cur_digit == 0);
        r_dg = (cur_digit + (r_dir ? 1 : 9)) % 10;
      end
      runOp($sformatf("random%0d", i), r_load, r_dir, r_ld, r_also, r_c, r_e, 4'(r_dg));
      cur_digit = r_dg;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
